// File: rtl/ptc_power_sequencer.sv
// ptc_power_sequencer: PTC rail/load power sequencing with PG and alert supervision.
// Ports: clk_axi/rst, start/stop/fault_clr/load_mask register bits, pg_*/alert_n pins in;
//   en_3v3/en_2v5/load_en enables out, state/fault/fault_code/alert_lat status out.
module ptc_power_sequencer #(
  parameter int PG_TIMEOUT_CYC   = 1_000_000,
  parameter int LOAD_STAGGER_CYC = 100_000,
  parameter int DEGLITCH_CYC     = 4,
  parameter int N_LOADS          = 6
) (
  input  logic               clk_axi,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               fault_clr,
  input  logic [N_LOADS-1:0] load_mask,
  input  logic               pg_3v3,
  input  logic               pg_2v5,
  input  logic [2:0]         alert_n,
  output logic               en_3v3,
  output logic               en_2v5,
  output logic [N_LOADS-1:0] load_en,
  output logic [2:0]         state,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [2:0]         alert_lat
);
  localparam int TMAX = (PG_TIMEOUT_CYC > LOAD_STAGGER_CYC) ?
                        PG_TIMEOUT_CYC : LOAD_STAGGER_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam int DW = $clog2(DEGLITCH_CYC + 1);
  localparam int IW = (N_LOADS > 1) ? $clog2(N_LOADS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_PG  = 3'd1;
  localparam logic [2:0] S_LOAD_ON  = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_LOAD_OFF = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  localparam logic [TW-1:0] T_PG_LAST = TW'(PG_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_ST_LAST = TW'(LOAD_STAGGER_CYC - 1);
  localparam logic [TW-1:0] T_SAT     = TW'(TMAX);
  localparam logic [DW-1:0] D_LAST    = DW'(DEGLITCH_CYC - 1);
  localparam logic [IW-1:0] I_LAST    = IW'(N_LOADS - 1);

  logic [1:0]         rst_sync_q, rst_sync_d;
  logic [1:0]         pg_s1_q, pg_s1_d, pg_s2_q, pg_s2_d;
  logic [2:0]         al_s1_q, al_s1_d, al_s2_q, al_s2_d;
  logic               start_prev_q, start_prev_d;
  logic               stop_prev_q, stop_prev_d;
  logic               clr_prev_q, clr_prev_d;
  logic [2:0]         state_q, state_d;
  logic               en_3v3_q, en_3v3_d;
  logic               en_2v5_q, en_2v5_d;
  logic [N_LOADS-1:0] load_en_q, load_en_d;
  logic [N_LOADS-1:0] mask_q, mask_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [DW-1:0]      deg_q, deg_d;
  logic               fault_q, fault_d;
  logic [1:0]         fault_code_q, fault_code_d;
  logic [2:0]         alert_lat_q, alert_lat_d;

  logic          hold;
  logic          start_edge, stop_edge, clr_edge;
  logic          pg_ok, alert_any, on, step_act, step_done;
  logic [TW-1:0] timer_inc;

  // Reset release is held for two clocks so every flop leaves reset
  // on the same edge.
  assign rst_sync_d = {rst_sync_q[0], 1'b0};
  assign hold       = rst_sync_q[1];

  assign start_edge = start & ~start_prev_q;
  assign stop_edge  = stop & ~stop_prev_q;
  assign clr_edge   = fault_clr & ~clr_prev_q;
  assign pg_ok      = &pg_s2_q;
  assign alert_any  = ~&al_s2_q;
  assign timer_inc  = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;

  always_comb begin
    pg_s1_d      = {pg_3v3, pg_2v5};
    pg_s2_d      = pg_s1_q;
    al_s1_d      = alert_n;
    al_s2_d      = al_s1_q;
    start_prev_d = start;
    stop_prev_d  = stop;
    clr_prev_d   = fault_clr;
    state_d      = state_q;
    en_3v3_d     = en_3v3_q;
    en_2v5_d     = en_2v5_q;
    load_en_d    = load_en_q;
    mask_d       = mask_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    deg_d        = deg_q;
    fault_code_d = fault_code_q;
    alert_lat_d  = alert_lat_q;
    on           = (state_q == S_LOAD_ON);
    step_act     = 1'b0;
    step_done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          mask_d   = load_mask;
          en_3v3_d = 1'b1;
          en_2v5_d = 1'b1;
          timer_d  = '0;
          deg_d    = '0;
          state_d  = S_WAIT_PG;
        end
      end
      S_WAIT_PG: begin
        timer_d = timer_inc;
        deg_d   = pg_ok ? deg_q + 1'b1 : '0;
        if (pg_ok && deg_q == D_LAST) begin
          state_d = S_LOAD_ON;
          idx_d   = '0;
          timer_d = '0;
        end else if (timer_q == T_PG_LAST) begin
          state_d      = S_FAULT;
          fault_code_d = 2'd1;
        end
      end
      S_LOAD_ON, S_LOAD_OFF: begin
        // A step staggers only when it actually toggles its load.
        step_act = on ? mask_q[idx_q] : load_en_q[idx_q];
        if (timer_q == '0) begin
          if (step_act) load_en_d[idx_q] = on;
          step_done = !step_act || (T_ST_LAST == '0);
          timer_d   = TW'(1);
        end else begin
          step_done = (timer_q == T_ST_LAST);
          timer_d   = timer_inc;
        end
        if (step_done) begin
          timer_d = '0;
          if (on) begin
            if (idx_q == I_LAST) state_d = S_RUN;
            else idx_d = idx_q + 1'b1;
          end else if (idx_q == '0) begin
            en_3v3_d = 1'b0;
            en_2v5_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      S_RUN: ;
      S_FAULT: begin
        if (clr_edge && !start) begin
          state_d      = S_IDLE;
          fault_code_d = 2'd0;
          alert_lat_d  = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop_edge && (state_q == S_WAIT_PG || on || state_q == S_RUN)) begin
      state_d   = S_LOAD_OFF;
      timer_d   = '0;
      load_en_d = load_en_q;
      idx_d     = on ? idx_q : I_LAST;
    end

    if (state_q != S_IDLE && state_q != S_FAULT) begin
      if (alert_any) begin
        state_d      = S_FAULT;
        fault_code_d = 2'd3;
        alert_lat_d  = ~al_s2_q;
      end else if (state_q != S_WAIT_PG && !pg_ok) begin
        state_d      = S_FAULT;
        fault_code_d = 2'd2;
      end
    end

    if (state_d == S_FAULT) begin
      en_3v3_d  = 1'b0;
      en_2v5_d  = 1'b0;
      load_en_d = '0;
    end
    fault_d = (state_d == S_FAULT);

    if (hold) begin
      pg_s1_d      = '0;
      pg_s2_d      = '0;
      al_s1_d      = '1;
      al_s2_d      = '1;
      start_prev_d = 1'b0;
      stop_prev_d  = 1'b0;
      clr_prev_d   = 1'b0;
      state_d      = S_IDLE;
      en_3v3_d     = 1'b0;
      en_2v5_d     = 1'b0;
      load_en_d    = '0;
      mask_d       = '0;
      idx_d        = '0;
      timer_d      = '0;
      deg_d        = '0;
      fault_d      = 1'b0;
      fault_code_d = 2'd0;
      alert_lat_d  = 3'd0;
    end
  end

  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      rst_sync_q   <= 2'b11;
      pg_s1_q      <= '0;
      pg_s2_q      <= '0;
      al_s1_q      <= '1;
      al_s2_q      <= '1;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      clr_prev_q   <= 1'b0;
      state_q      <= S_IDLE;
      en_3v3_q     <= 1'b0;
      en_2v5_q     <= 1'b0;
      load_en_q    <= '0;
      mask_q       <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      deg_q        <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
      alert_lat_q  <= 3'd0;
    end else begin
      rst_sync_q   <= rst_sync_d;
      pg_s1_q      <= pg_s1_d;
      pg_s2_q      <= pg_s2_d;
      al_s1_q      <= al_s1_d;
      al_s2_q      <= al_s2_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      clr_prev_q   <= clr_prev_d;
      state_q      <= state_d;
      en_3v3_q     <= en_3v3_d;
      en_2v5_q     <= en_2v5_d;
      load_en_q    <= load_en_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      deg_q        <= deg_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      alert_lat_q  <= alert_lat_d;
    end
  end

  assign en_3v3     = en_3v3_q;
  assign en_2v5     = en_2v5_q;
  assign load_en    = load_en_q;
  assign state      = state_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign alert_lat  = alert_lat_q;
endmodule

// File: tb/tb_ptc_power_sequencer.sv
// tb_ptc_power_sequencer: directed and randomized bench for ptc_power_sequencer.
// Expected timing comes from an arithmetic schedule of PG deglitch, timeout and load staggers.
module tb_ptc_power_sequencer;
  localparam int PGT = 100;
  localparam int LS  = 10;
  localparam int DG  = 4;
  localparam int N   = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, stop = 1'b0, fault_clr = 1'b0;
  logic [N-1:0] load_mask = '0;
  logic         pg_3v3 = 1'b0, pg_2v5 = 1'b0;
  logic [2:0]   alert_n = 3'b111;
  logic         en_3v3, en_2v5, fault;
  logic [N-1:0] load_en;
  logic [2:0]   state, alert_lat;
  logic [1:0]   fault_code;
  int checks = 0;
  int errors = 0;

  ptc_power_sequencer #(
    .PG_TIMEOUT_CYC(PGT), .LOAD_STAGGER_CYC(LS),
    .DEGLITCH_CYC(DG), .N_LOADS(N)
  ) dut (
    .clk_axi(clk), .rst(rst), .start(start), .stop(stop),
    .fault_clr(fault_clr), .load_mask(load_mask),
    .pg_3v3(pg_3v3), .pg_2v5(pg_2v5), .alert_n(alert_n),
    .en_3v3(en_3v3), .en_2v5(en_2v5), .load_en(load_en),
    .state(state), .fault(fault), .fault_code(fault_code),
    .alert_lat(alert_lat)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] pack(input logic f, input logic [1:0] c,
                                       input logic r, input logic [2:0] s,
                                       input logic [N-1:0] l);
    return 32'({f, c, r, r, s, l});
  endfunction

  function automatic logic [31:0] obs();
    return 32'({fault, fault_code, en_3v3, en_2v5, state, load_en});
  endfunction

  // PG pattern: both low until d0, then pg_3v3 drops for g ticks after h high ticks.
  task automatic power_up(input logic [N-1:0] m, input int d0, input int h,
                          input int g, input int stop_at, output bit ok);
    bit hist[0:PGT];
    int run, acc, total;
    int st[N];
    bit vis, done;
    logic [N-1:0] exp_ld;
    pg_3v3 = 1'b0;
    pg_2v5 = 1'b0;
    repeat (3) tick();
    chk("idle", obs(), pack(0, 0, 0, 0, '0));
    load_mask = m;
    start = 1'b1;
    tick();
    load_mask = N'($urandom);
    chk("rails_on", obs(), pack(0, 0, 1, 3'd1, '0));
    hist[0] = 1'b0;
    run = 0;
    done = 1'b0;
    ok = 1'b0;
    for (int w = 1; w <= PGT && !done; w++) begin
      pg_2v5 = (w > d0);
      pg_3v3 = (w > d0) && !((w > d0 + h) && (w <= d0 + h + g));
      hist[w] = pg_2v5 & pg_3v3;
      tick();
      vis = (w >= 2) ? hist[w-2] : 1'b0;
      run = vis ? run + 1 : 0;
      if (run == DG) begin
        done = 1'b1;
        ok = 1'b1;
        chk("pg_accept", obs(), pack(0, 0, 1, 3'd2, '0));
      end else if (w == PGT) begin
        done = 1'b1;
        chk("pg_timeout", obs(), pack(1, 2'd1, 0, 3'd5, '0));
      end else begin
        chk("wait_pg", obs(), pack(0, 0, 1, 3'd1, '0));
      end
    end
    if (ok) begin
      acc = 1;
      for (int i = 0; i < N; i++) begin
        st[i] = acc;
        acc += m[i] ? LS : 1;
      end
      total = acc - 1;
      for (int c = 1; c <= total; c++) begin
        tick();
        exp_ld = '0;
        for (int i = 0; i < N; i++)
          if (m[i] && st[i] <= c) exp_ld[i] = 1'b1;
        chk("load_on", obs(), pack(0, 0, 1, (c == total) ? 3'd3 : 3'd2, exp_ld));
        if (c == stop_at) break;
      end
    end
  endtask

  task automatic power_down(input logic [N-1:0] cur);
    int ft[N];
    int acc, total;
    logic [N-1:0] exp_ld;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_edge", obs(), pack(0, 0, 1, 3'd4, cur));
    acc = 1;
    for (int i = N - 1; i >= 0; i--) begin
      ft[i] = acc;
      acc += cur[i] ? LS : 1;
    end
    total = acc - 1;
    for (int c = 1; c <= total; c++) begin
      tick();
      exp_ld = cur;
      for (int i = 0; i < N; i++)
        if (ft[i] <= c) exp_ld[i] = 1'b0;
      chk("load_off", obs(),
          (c == total) ? pack(0, 0, 0, 3'd0, '0) : pack(0, 0, 1, 3'd4, exp_ld));
    end
  endtask

  task automatic inject(input logic [2:0] al, input bit pgd, input logic [N-1:0] cur,
                        input logic [1:0] code, input logic [2:0] lat);
    alert_n = al;
    if (pgd) pg_2v5 = 1'b0;
    repeat (2) begin
      tick();
      chk("pre_fault", obs(), pack(0, 0, 1, 3'd3, cur));
    end
    tick();
    chk("fault_entry", obs(), pack(1, code, 0, 3'd5, '0));
    chk("alert_lat", 32'(alert_lat), 32'(lat));
    alert_n = 3'b111;
  endtask

  task automatic clear_fault();
    start = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("fault_clear", obs(), pack(0, 0, 0, 3'd0, '0));
    chk("lat_clear", 32'(alert_lat), 32'd0);
  endtask

  initial begin
    bit ok;
    logic [N-1:0] m;
    logic [2:0] al;

    repeat (2) tick();
    chk("reset_out", obs(), pack(0, 0, 0, 3'd0, '0));
    chk("reset_lat", 32'(alert_lat), 32'd0);
    rst = 1'b0;

    power_up(6'b101101, 5, 0, 0, 0, ok);
    chk("up_ok", 32'(ok), 32'd1);
    start = 1'b0;
    power_down(6'b101101);

    power_up(N'($urandom), PGT + 10, 0, 0, 0, ok);
    chk("timeout_flag", 32'(ok), 32'd0);
    clear_fault();

    m = N'($urandom);
    power_up(m, $urandom_range(0, 5), 0, 0, 0, ok);
    inject(3'b101, 1'b0, m, 2'd3, 3'b010);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_ignored", obs(), pack(1, 2'd3, 0, 3'd5, '0));
    tick();
    clear_fault();

    power_up(6'b111111, 3, 0, 0, 0, ok);
    start = 1'b0;
    power_down(6'b111111);

    m = N'($urandom);
    power_up(m, 2, $urandom_range(1, DG - 1), 3, 0, ok);
    start = 1'b0;
    inject(3'b111, 1'b1, m, 2'd2, 3'b000);
    clear_fault();

    m = N'($urandom);
    al = 3'($urandom_range(0, 6));
    power_up(m, 1, 0, 0, 0, ok);
    start = 1'b0;
    inject(al, 1'b1, m, 2'd3, ~al);
    clear_fault();

    for (int k = 0; k < 4; k++) begin
      m = (k == 0) ? '0 : N'($urandom);
      power_up(m, $urandom_range(0, 8), 0, 0, 0, ok);
      start = 1'b0;
      power_down(m);
    end

    power_up(6'b111111, 0, 0, 0, 15, ok);
    chk("mid_load_on", obs(), pack(0, 0, 1, 3'd2, 6'b000011));
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", obs(), pack(0, 0, 0, 3'd0, '0));
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("post_rst", obs(), pack(0, 0, 0, 3'd0, '0));
    m = N'($urandom);
    power_up(m, 4, 0, 0, 0, ok);
    chk("post_rst_up", 32'(ok), 32'd1);
    start = 1'b0;
    power_down(m);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
